// File: rtl/change_dispenser.sv
// Pays a latched balance back out as coins, one per hopper handshake, choosing
// denominations greedily (10, 5, 1) against per-denomination stock counters.
module change_dispenser #(
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned N1_INIT     = 8,
  parameter int unsigned N5_INIT     = 4,
  parameter int unsigned N10_INIT    = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] balance,
  input  logic       restock,
  output logic [2:0] coin,
  output logic       coin_valid,
  input  logic       coin_ack,
  output logic [7:0] remain,
  output logic       busy,
  output logic       done,
  output logic       shortfall,
  output logic       fault
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] COIN_1  = 3'b001;
  localparam logic [2:0] COIN_5  = 3'b010;
  localparam logic [2:0] COIN_10 = 3'b100;

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FIN} state_e;

  state_e             state_q, state_d;
  logic [2:0]         coin_q, coin_d;
  logic               coin_valid_q, coin_valid_d;
  logic [7:0]         remain_q, remain_d;
  logic               done_q, done_d;
  logic               shortfall_q, shortfall_d;
  logic               fault_q, fault_d;
  logic [STOCK_W-1:0] stock1_q, stock1_d;
  logic [STOCK_W-1:0] stock5_q, stock5_d;
  logic [STOCK_W-1:0] stock10_q, stock10_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  always_comb begin
    state_d      = state_q;
    coin_d       = coin_q;
    coin_valid_d = coin_valid_q;
    remain_d     = remain_q;
    done_d       = 1'b0;
    shortfall_d  = shortfall_q;
    fault_d      = fault_q;
    stock1_d     = stock1_q;
    stock5_d     = stock5_q;
    stock10_d    = stock10_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (restock) begin
          stock1_d  = STOCK_W'(N1_INIT);
          stock5_d  = STOCK_W'(N5_INIT);
          stock10_d = STOCK_W'(N10_INIT);
        end
        if (start) begin
          remain_d    = balance;
          shortfall_d = 1'b0;
          fault_d     = 1'b0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        tmo_d = '0;
        if (remain_q == 8'd0) begin
          state_d = FIN;
        end else if (remain_q >= 8'd10 && stock10_q != '0) begin
          coin_d       = COIN_10;
          coin_valid_d = 1'b1;
          state_d      = ISSUE;
        end else if (remain_q >= 8'd5 && stock5_q != '0) begin
          coin_d       = COIN_5;
          coin_valid_d = 1'b1;
          state_d      = ISSUE;
        end else if (stock1_q != '0) begin
          coin_d       = COIN_1;
          coin_valid_d = 1'b1;
          state_d      = ISSUE;
        end else begin
          shortfall_d = 1'b1;
          state_d     = FIN;
        end
      end
      ISSUE: begin
        if (coin_ack) begin
          // The denomination in flight is recovered from the held coin code.
          unique case (coin_q)
            COIN_10: begin
              remain_d = remain_q - 8'd10;
              if (stock10_q != '0) stock10_d = stock10_q - 1'b1;
            end
            COIN_5: begin
              remain_d = remain_q - 8'd5;
              if (stock5_q != '0) stock5_d = stock5_q - 1'b1;
            end
            default: begin
              remain_d = remain_q - 8'd1;
              if (stock1_q != '0) stock1_d = stock1_q - 1'b1;
            end
          endcase
          coin_d       = '0;
          coin_valid_d = 1'b0;
          state_d      = SELECT;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          fault_d      = 1'b1;
          coin_d       = '0;
          coin_valid_d = 1'b0;
          state_d      = FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      coin_q       <= '0;
      coin_valid_q <= 1'b0;
      remain_q     <= '0;
      done_q       <= 1'b0;
      shortfall_q  <= 1'b0;
      fault_q      <= 1'b0;
      stock1_q     <= STOCK_W'(N1_INIT);
      stock5_q     <= STOCK_W'(N5_INIT);
      stock10_q    <= STOCK_W'(N10_INIT);
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      coin_q       <= coin_d;
      coin_valid_q <= coin_valid_d;
      remain_q     <= remain_d;
      done_q       <= done_d;
      shortfall_q  <= shortfall_d;
      fault_q      <= fault_d;
      stock1_q     <= stock1_d;
      stock5_q     <= stock5_d;
      stock10_q    <= stock10_d;
      tmo_q        <= tmo_d;
    end
  end

  assign coin       = coin_q;
  assign coin_valid = coin_valid_q;
  assign remain     = remain_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign shortfall  = shortfall_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and randomized payouts checked against a
// transaction-level greedy payout model with its own stock bookkeeping.
module tb_change_dispenser;

  localparam int N1 = 8;
  localparam int N5 = 4;
  localparam int N10 = 4;

  logic       clk = 1'b0;
  logic       reset, start, restock, coin_ack;
  logic [7:0] balance;
  logic [2:0] coin;
  logic       coin_valid, busy, done, shortfall, fault;
  logic [7:0] remain;

  int checks = 0;
  int errors = 0;

  // model state
  int s1, s5, s10;
  int exp_coin[$];
  int exp_rem[$];
  int exp_final;
  int exp_sf;

  change_dispenser #(
    .STOCK_W(4), .N1_INIT(N1), .N5_INIT(N5), .N10_INIT(N10), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .balance(balance),
    .restock(restock), .coin(coin), .coin_valid(coin_valid),
    .coin_ack(coin_ack), .remain(remain), .busy(busy), .done(done),
    .shortfall(shortfall), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int code_of(input int d);
    return (d == 10) ? 4 : (d == 5) ? 2 : 1;
  endfunction

  // Greedy plan: list of coin values and the amount owed before each one.
  task automatic build_plan(input int bal);
    int r;
    r = bal;
    exp_coin.delete();
    exp_rem.delete();
    exp_sf = 0;
    while (r > 0) begin
      exp_rem.push_back(r);
      if (r >= 10 && s10 > 0) begin exp_coin.push_back(10); s10--; r -= 10; end
      else if (r >= 5 && s5 > 0) begin exp_coin.push_back(5); s5--; r -= 5; end
      else if (s1 > 0) begin exp_coin.push_back(1); s1--; r -= 1; end
      else begin void'(exp_rem.pop_back()); exp_sf = 1; break; end
    end
    exp_final = r;
  endtask

  task automatic restock_model();
    s1 = N1; s5 = N5; s10 = N10;
  endtask

  task automatic pay(input int bal, input bit rs, input int fixed_dly, input bit noise);
    int dly;
    if (rs) restock_model();
    build_plan(bal);
    start = 1'b1; balance = bal[7:0]; restock = rs;
    @(negedge clk);
    start = 1'b0; restock = 1'b0; balance = 8'($urandom);
    check("sel_busy", busy, 1);
    check("sel_remain", remain, bal);
    check("sel_valid", coin_valid, 0);
    check("sel_shortfall", shortfall, 0);
    check("sel_fault", fault, 0);
    foreach (exp_coin[k]) begin
      @(negedge clk);
      check("coin_valid", coin_valid, 1);
      check("coin_code", coin, code_of(exp_coin[k]));
      check("coin_remain", remain, exp_rem[k]);
      dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 10));
      for (int j = 0; j < dly; j++) begin
        coin_ack = 1'b0;
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          balance = 8'd9;
          restock = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("hold_valid", coin_valid, 1);
        check("hold_code", coin, code_of(exp_coin[k]));
        check("hold_remain", remain, exp_rem[k]);
      end
      coin_ack = 1'b1; start = 1'b0; restock = 1'b0;
      @(negedge clk);
      coin_ack = 1'b0;
      check("ack_valid", coin_valid, 0);
      check("ack_code", coin, 0);
      check("ack_remain", remain, exp_rem[k] - exp_coin[k]);
    end
    @(negedge clk);
    check("fin_done", done, 0);
    check("fin_busy", busy, 1);
    check("fin_valid", coin_valid, 0);
    @(negedge clk);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_remain", remain, exp_final);
    check("end_shortfall", shortfall, exp_sf);
    check("end_fault", fault, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("hold_final_remain", remain, exp_final);
  endtask

  task automatic timeout_run(input int bal);
    int t1, t5, t10;
    t1 = s1; t5 = s5; t10 = s10;
    build_plan(bal);
    s1 = t1; s5 = t5; s10 = t10;
    start = 1'b1; balance = bal[7:0];
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("to_first_valid", coin_valid, 1);
    check("to_first_code", coin, code_of(exp_coin[0]));
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check("to_wait_valid", coin_valid, 1);
      check("to_wait_fault", fault, 0);
    end
    @(negedge clk);
    check("to_fault", fault, 1);
    check("to_valid", coin_valid, 0);
    check("to_code", coin, 0);
    check("to_remain", remain, bal);
    check("to_done_early", done, 0);
    @(negedge clk);
    check("to_done", done, 1);
    check("to_busy", busy, 0);
    check("to_fault_held", fault, 1);
    @(negedge clk);
    check("to_done_pulse", done, 0);
    check("to_fault_kept", fault, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; restock = 1'b0; coin_ack = 1'b0; balance = '0;
    restock_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_coin", coin, 0);
    check("rst_valid", coin_valid, 0);
    check("rst_remain", remain, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);

    // plain payout with noise while busy: 10,5,1,1
    pay(17, 0, -1, 1);

    // exhaust 5s, then seven 1s
    pay(5, 1, -1, 0);
    repeat (3) pay(5, 0, -1, 0);
    pay(7, 0, -1, 0);

    // shortfall with 1s=2, 5s=0, 10s=0, then restock+start together
    pay(40, 1, -1, 0);
    pay(20, 0, -1, 0);
    pay(6, 0, -1, 0);
    pay(4, 0, -1, 0);
    pay(2, 1, -1, 0);

    // fixed ack delay of 5, then timeout, then fault clears on next start
    pay(12, 0, 5, 0);
    timeout_run(3);
    pay(0, 0, -1, 0);

    // reset mid-payout restores stock; drain all stock to observe it
    start = 1'b1; balance = 8'd17;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_valid_before", coin_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_valid", coin_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_remain", remain, 0);
    check("mid_coin", coin, 0);
    restock_model();
    pay(255, 0, 0, 0);

    for (int i = 0; i < 20; i++)
      pay(int'($urandom_range(0, 60)), ($urandom_range(0, 3) == 0), -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
